// File: rtl/bus_arbiter_rr_pkg.sv
// Shared types and constants for the parallel-request bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        HOLD    = 2'd2,
        PREEMPT = 2'd3
    } arb_state_t;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Masked priority encoder: lowest valid requester (fixed) or first valid
// requester at or after the pointer, wrapping (round-robin).
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    input  logic         mode,
    output logic [W-1:0] winner,
    output logic         found
);

    logic [N-1:0] cand;
    logic [W-1:0] sel;
    int           base;
    int           idx;

    always_comb begin
        cand   = req & valid;
        base   = (mode == ARB_RR) ? int'(ptr) : 0;
        idx    = 0;
        sel    = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (base + k) % N;
            sel = W'(idx);
            if (!found && cand[sel]) begin
                found  = 1'b1;
                winner = sel;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-master / M-slave bus arbiter with fixed or round-robin selection,
// hold-time preemption and a bounded release window with forced revoke.
//
//  state   | meaning
//  IDLE    | no grant, all selects 0; arbitrate among valid requests
//  GRANT   | first grant cycle; hold counter cleared
//  HOLD    | holder owns the bus; wall-clock hold counter runs
//  PREEMPT | holder asked to release; revoked when release window expires
module bus_arbiter_rr
    import bus_arb_pkg::*;
#(
    parameter int NO_MASTERS = 4,
    parameter int NO_SLAVES  = 3,
    parameter int THRESH     = 1000,
    parameter int REL_WAIT   = 16,
    parameter int S_ID_WIDTH = $clog2(NO_SLAVES + 1),
    parameter int M_ID_WIDTH = $clog2(NO_MASTERS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mode,
    input  logic [NO_MASTERS-1:0]            req,
    input  logic [NO_MASTERS*S_ID_WIDTH-1:0] req_sid,
    input  logic [NO_MASTERS-1:0]            done,
    input  logic                             ready,
    output logic [NO_MASTERS-1:0]            grant,
    output logic [NO_MASTERS-1:0]            preempt,
    output logic [M_ID_WIDTH-1:0]            m_select,
    output logic [S_ID_WIDTH-1:0]            s_select,
    output logic [S_ID_WIDTH+M_ID_WIDTH-1:0] bus_state,
    output logic                             busy
);

    localparam int HW = $clog2(THRESH + 1);
    localparam int RW = $clog2(REL_WAIT + 1);

    arb_state_t            state;
    logic [HW-1:0]         hold_cnt;
    logic [RW-1:0]         rel_cnt;
    logic [M_ID_WIDTH-1:0] rr_ptr;
    logic [M_ID_WIDTH-1:0] winner;
    logic                  found;
    logic [S_ID_WIDTH-1:0] sid_arr [NO_MASTERS];
    logic [NO_MASTERS-1:0] sid_ok;
    logic                  holder_done;
    logic                  other_req;

    // Slave ready does not gate the hold counter: hold time is wall-clock.
    logic unused_ready;
    assign unused_ready = ready;

    always_comb begin
        for (int i = 0; i < NO_MASTERS; i++) begin
            sid_arr[i] = req_sid[i*S_ID_WIDTH +: S_ID_WIDTH];
            sid_ok[i]  = (sid_arr[i] != '0) && (int'(sid_arr[i]) <= NO_SLAVES);
        end
    end

    assign holder_done = done[m_select];
    assign other_req   = |(req & sid_ok & ~grant);
    assign bus_state   = {s_select, m_select};

    rr_pick #(.N(NO_MASTERS), .W(M_ID_WIDTH)) u_pick (
        .req    (req),
        .valid  (sid_ok),
        .ptr    (rr_ptr),
        .mode   (mode),
        .winner (winner),
        .found  (found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            preempt  <= '0;
            m_select <= '0;
            s_select <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            rel_cnt  <= '0;
            rr_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state    <= GRANT;
                        grant    <= NO_MASTERS'(1) << winner;
                        m_select <= winner;
                        s_select <= sid_arr[winner];
                        busy     <= 1'b1;
                        rr_ptr   <= (winner == M_ID_WIDTH'(NO_MASTERS - 1)) ? '0 : winner + 1'b1;
                    end
                end
                GRANT: begin
                    hold_cnt <= '0;
                    state    <= HOLD;
                end
                HOLD: begin
                    // A done in the threshold cycle takes priority over preemption.
                    if (holder_done) begin
                        state    <= IDLE;
                        grant    <= '0;
                        preempt  <= '0;
                        m_select <= '0;
                        s_select <= '0;
                        busy     <= 1'b0;
                    end else if (hold_cnt != HW'(THRESH)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (other_req) begin
                        state   <= PREEMPT;
                        preempt <= grant;
                        rel_cnt <= '0;
                    end
                end
                PREEMPT: begin
                    if (holder_done || (rel_cnt == RW'(REL_WAIT - 1))) begin
                        state    <= IDLE;
                        grant    <= '0;
                        preempt  <= '0;
                        m_select <= '0;
                        s_select <= '0;
                        busy     <= 1'b0;
                    end else begin
                        rel_cnt <= rel_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: cycle-level ownership model plus directed scenarios.
module tb_bus_arbiter_rr;

    localparam int NM = 4;
    localparam int NS = 3;
    localparam int TH = 8;
    localparam int RWT = 4;
    localparam int SW = 2;
    localparam int MW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mode = 1'b0;
    logic           ready = 1'b1;
    logic [NM-1:0]  req = '0;
    logic [NM-1:0]  done = '0;
    logic [NM*SW-1:0] req_sid = '0;
    logic [NM-1:0]  grant;
    logic [NM-1:0]  preempt;
    logic [MW-1:0]  m_select;
    logic [SW-1:0]  s_select;
    logic [SW+MW-1:0] bus_state;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    bus_arbiter_rr #(
        .NO_MASTERS(NM), .NO_SLAVES(NS), .THRESH(TH), .REL_WAIT(RWT),
        .S_ID_WIDTH(SW), .M_ID_WIDTH(MW)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .req(req), .req_sid(req_sid),
        .done(done), .ready(ready), .grant(grant), .preempt(preempt),
        .m_select(m_select), .s_select(s_select), .bus_state(bus_state), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Ownership model: who holds the bus, cycles since grant, release-window age.
    int m_holder = -1;
    int m_age    = 0;
    int m_pre    = -1;
    int m_ptr    = 0;
    int m_sid    = 0;

    function automatic int sid_of(input int i);
        return int'(req_sid[i*SW +: SW]);
    endfunction

    function automatic bit is_valid(input int i);
        return req[i] && sid_of(i) != 0 && sid_of(i) <= NS;
    endfunction

    function automatic int pick();
        int base = mode ? m_ptr : 0;
        for (int k = 0; k < NM; k++) begin
            if (is_valid((base + k) % NM)) return (base + k) % NM;
        end
        return -1;
    endfunction

    function automatic bit others_waiting();
        for (int i = 0; i < NM; i++)
            if (i != m_holder && is_valid(i)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_holder = -1; m_pre = -1; m_ptr = 0; m_age = 0;
        end else if (m_holder < 0) begin
            w = pick();
            if (w >= 0) begin
                m_holder = w; m_sid = sid_of(w); m_age = 0; m_pre = -1;
                m_ptr = (w + 1) % NM;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (m_pre < 0) begin
            if (done[m_holder]) m_holder = -1;
            else begin
                // hold counter value is cycles spent in HOLD, saturating at TH
                if (m_age - 1 >= TH && others_waiting()) m_pre = 0;
                m_age++;
            end
        end else begin
            if (done[m_holder] || m_pre == RWT - 1) begin m_holder = -1; m_pre = -1; end
            else m_pre++;
        end
    end

    logic [NM-1:0] e_grant, e_pre;
    logic [MW-1:0] e_msel;
    logic [SW-1:0] e_ssel;

    always @(negedge clk) begin
        e_grant = (m_holder >= 0) ? (NM'(1) << m_holder) : '0;
        e_pre   = (m_pre >= 0) ? e_grant : '0;
        e_msel  = (m_holder >= 0) ? MW'(m_holder) : '0;
        e_ssel  = (m_holder >= 0) ? SW'(m_sid) : '0;
        chk("model_grant", 32'(grant), 32'(e_grant));
        chk("model_preempt", 32'(preempt), 32'(e_pre));
        chk("model_m_select", 32'(m_select), 32'(e_msel));
        chk("model_s_select", 32'(s_select), 32'(e_ssel));
        chk("model_bus_state", 32'(bus_state), 32'({e_ssel, e_msel}));
        chk("model_busy", 32'(busy), 32'(m_holder >= 0));
    end

    task automatic set_sid(input int i, input int v);
        req_sid[i*SW +: SW] = SW'(v);
    endtask

    task automatic pulse_done(input int i);
        done[i] = 1'b1;
        @(negedge clk);
        done = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; done = '0; req_sid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int max, output int n);
        n = 0;
        while (grant == '0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (grant == '0) begin
            checks++; errors++;
            $display("FAIL wait_grant: no grant within %0d cycles", max);
            n = -1;
        end
    endtask

    task automatic wait_preempt(input int max, output int n);
        n = 0;
        while (preempt == '0 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (preempt == '0) begin
            checks++; errors++;
            $display("FAIL wait_preempt: no preempt within %0d cycles", max);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, p;
        repeat (3) @(negedge clk);
        chk("reset_grant", 32'(grant), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_bus_state", 32'(bus_state), 0);
        rst = 1'b0;

        // fixed priority, m1 and m3 both want slave 2
        mode = 1'b0; set_sid(1, 2); set_sid(3, 2); req = 4'b1010;
        @(negedge clk);
        chk("t1_grant", 32'(grant), 32'b0010);
        chk("t1_m_select", 32'(m_select), 1);
        chk("t1_s_select", 32'(s_select), 2);
        chk("t1_bus_state", 32'(bus_state), 32'b1001);
        @(negedge clk);
        req = 4'b1000;
        pulse_done(1);
        chk("t1_release", 32'(grant), 0);
        @(negedge clk);
        chk("t1_next_grant", 32'(grant), 32'b1000);

        // round-robin, everybody requesting
        do_reset();
        mode = 1'b1;
        set_sid(0, 1); set_sid(1, 2); set_sid(2, 3); set_sid(3, 1);
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            wait_grant(10, n);
            chk("t2_order", 32'(m_select), 32'(exp_order[r]));
            if (r > 0) chk("t2_idle_gap", 32'(n), 1);
            repeat (5) @(negedge clk);
            pulse_done(exp_order[r]);
        end

        // threshold preemption followed by a voluntary done
        do_reset();
        mode = 1'b0; set_sid(0, 1); req = 4'b0001;
        wait_grant(5, n);
        repeat (3) @(negedge clk);
        set_sid(2, 3); req[2] = 1'b1;
        p = 3;
        while (preempt == '0 && p < 30) begin
            @(negedge clk);
            p++;
        end
        chk("t3_preempt_cycle", 32'(p), 10);
        chk("t3_preempt_vec", 32'(preempt), 32'b0001);
        repeat (2) @(negedge clk);
        req[0] = 1'b0;
        pulse_done(0);
        chk("t3_release", 32'(grant), 0);
        @(negedge clk);
        chk("t3_regrant", 32'(grant), 32'b0100);
        chk("t3_regrant_sid", 32'(s_select), 3);

        // sole holder never preempted; forced revoke after the release window
        do_reset();
        mode = 1'b0; set_sid(0, 1); req = 4'b0001;
        wait_grant(5, n);
        req = '0;
        repeat (15) @(negedge clk);
        chk("t4_sole_no_preempt", 32'(preempt), 0);
        chk("t4_req_drop_keeps_grant", 32'(grant), 32'b0001);
        set_sid(1, 1); req[1] = 1'b1;
        wait_preempt(10, p);
        n = 0;
        while (grant[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_revoke_cycles", 32'(n), 4);
        chk("t4_preempt_dropped", 32'(preempt), 0);

        // sid 0 ignored, non-holder done ignored, done beats threshold
        do_reset();
        mode = 1'b0; set_sid(0, 0); req = 4'b0001;
        repeat (6) @(negedge clk);
        chk("t5_sid0_busy", 32'(busy), 0);
        set_sid(1, 1); req = 4'b0011;
        wait_grant(5, n);
        chk("t5_grant_m1", 32'(m_select), 1);
        repeat (2) @(negedge clk);
        pulse_done(3);
        chk("t5_foreign_done", 32'(grant), 32'b0010);
        set_sid(2, 2); req[2] = 1'b1;
        repeat (6) @(negedge clk);
        req[1] = 1'b0;
        pulse_done(1);
        chk("t5_done_wins_grant", 32'(grant), 0);
        chk("t5_done_wins_preempt", 32'(preempt), 0);
        @(negedge clk);
        chk("t5_next_grant", 32'(grant), 32'b0100);

        // reset mid-transfer clears outputs and the round-robin pointer
        do_reset();
        mode = 1'b1; set_sid(2, 1); req = 4'b0100;
        wait_grant(5, n);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NM; i++) set_sid(i, 1);
        req = 4'b1111;
        @(negedge clk);
        chk("t6_rst_grant", 32'(grant), 0);
        chk("t6_rst_preempt", 32'(preempt), 0);
        chk("t6_rst_bus_state", 32'(bus_state), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        wait_grant(5, n);
        chk("t6_rr_restart", 32'(m_select), 0);
        req = '0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
